// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
package fifo_stream_reader_pkg;

    // Default byte width; must match the FIFO data width.
    localparam int DATA_W_DEF = 8;

    // Reader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Beat counter width: max(1, clog2(frame_len)).
    function automatic int beat_width(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready byte stream carrying a frame-end marker.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_stream_skid_buf.sv
// Two-entry in-order buffer: e0 is the head presented downstream,
// e1 holds the byte that arrived while the head was stalled.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,       // only asserted while occ_o < 2
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,        // only asserted while occ_o != 0
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] e0_q, e0_d;
    logic [DATA_W-1:0] e1_q, e1_d;
    logic [1:0]        occ_q, occ_d;

    // Next-state for entries and occupancy; order is always preserved.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    e0_d = push_data_i;
                end else begin
                    e1_d = push_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while a new byte arrives: occupancy unchanged.
                if (occ_q == 2'd1) begin
                    e0_d = push_data_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Buffer registers; reset discards any buffered bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign data_o = e0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a byte FIFO into a framed valid/ready stream and counts frames.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_W-1:0]     fifo_data_i,
    output logic                  fifo_read_en_o,
    fifo_stream_reader_if.master  m_if,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      frame_count_o
);

    localparam int                BEAT_W    = beat_width(FRAME_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    logic [1:0]        occ;
    logic [1:0]        occ_after;
    logic [DATA_W-1:0] head;
    logic              pop_fifo;
    logic              out_valid;
    logic              out_last;
    logic              xfer;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    // Pop only from registered occupancy so m_ready never reaches the FIFO.
    assign pop_fifo  = enable_i && !fifo_empty_i && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_last  = out_valid && (beat_q == LAST_BEAT);
    assign xfer      = out_valid && m_if.m_ready;
    assign occ_after = occ + 2'(pop_fifo) - 2'(xfer);

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (pop_fifo),
        .push_data_i (fifo_data_i),
        .pop_i       (xfer),
        .data_o      (head),
        .occ_o       (occ)
    );

    // Beat position within the frame and completed-frame count.
    always_comb begin
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;
        if (xfer) begin
            if (out_last) begin
                beat_d      = '0;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Framing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            beat_q      <= beat_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Control FSM next state, judged on occupancy after this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_fifo) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d = (occ_after != 2'd0) ? ST_DRAIN : ST_IDLE;
                end else if ((occ_after == 2'd0) && fifo_empty_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (enable_i) begin
                    state_d = ((occ_after == 2'd0) && fifo_empty_i) ? ST_IDLE : ST_RUN;
                end else if (occ_after == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign fifo_read_en_o = pop_fifo;
    assign m_if.m_valid   = out_valid;
    assign m_if.m_data    = head;
    assign m_if.m_last    = out_last;
    assign busy_o         = (state_q != ST_IDLE);
    assign frame_count_o  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a queue models the FIFO, popped bytes are pushed to an
// expected queue and compared when the DUT transfers them downstream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_read_en;
    logic          busy;
    logic [CW-1:0] frame_count;

    fifo_stream_reader_if #(.DATA_W(DW)) s_if ();

    fifo_stream_reader #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .fifo_empty_i   (fifo_empty),
        .fifo_data_i    (fifo_data),
        .fifo_read_en_o (fifo_read_en),
        .m_if           (s_if),
        .busy_o         (busy),
        .frame_count_o  (frame_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            force_empty = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;
    int            beat_m = 0;
    logic [CW-1:0] fc_m = '0;
    int            pops_seen = 0;
    bit            mv_sample = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] last_frame_byte = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void drive_fifo();
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    // One clock: sample at negedge, then apply FIFO pop just after posedge.
    task automatic cycle();
        bit rd;
        bit xf;
        bit exp_last;
        logic [DW-1:0] e;
        @(negedge clk);
        check_val("rd_while_empty", 32'(fifo_read_en & fifo_empty), 32'd0);
        check_val("frame_count", 32'(frame_count), 32'(fc_m));
        if (prev_stall) begin
            check_val("stall_data", 32'(s_if.m_data), 32'(prev_data));
            check_val("stall_last", 32'(s_if.m_last), 32'(prev_last));
        end
        rd        = fifo_read_en;
        xf        = s_if.m_valid && s_if.m_ready;
        mv_sample = s_if.m_valid;
        if (rd) pops_seen++;
        if (xf) begin
            check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e        = exp_q.pop_front();
                exp_last = (beat_m == FL - 1);
                check_val("m_data", 32'(s_if.m_data), 32'(e));
                check_val("m_last", 32'(s_if.m_last), 32'(exp_last));
                $display("xfer data=0x%02h last=%0b beat=%0d", s_if.m_data, s_if.m_last, beat_m);
                if (exp_last) begin
                    beat_m          = 0;
                    fc_m            = fc_m + 1'b1;
                    last_frame_byte = e;
                end else begin
                    beat_m++;
                end
            end
        end
        prev_stall = s_if.m_valid && !s_if.m_ready;
        prev_data  = s_if.m_data;
        prev_last  = s_if.m_last;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
        drive_fifo();
    endtask

    // Run until the reader is idle with nothing buffered; returns cycles used.
    task automatic run_to_idle(input int budget, output int used);
        used = 0;
        while ((busy || s_if.m_valid) && used < budget) begin
            cycle();
            used++;
        end
        check_val("idle_timeout", 32'(used < budget), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        beat_m     = 0;
        fc_m       = '0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_fifo(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
        drive_fifo();
    endtask

    initial begin
        int used;
        s_if.m_ready = 1'b0;
        load_fifo(8'h11, 1);

        // Reset state with a byte waiting in the FIFO.
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(s_if.m_valid), 32'd0);
        check_val("rst_data", 32'(s_if.m_data), 32'd0);
        check_val("rst_last", 32'(s_if.m_last), 32'd0);
        check_val("rst_rd", 32'(fifo_read_en), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_fc", 32'(frame_count), 32'd0);

        // Release: pop in first cycle, byte visible one cycle later.
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        enable       = 1'b1;
        s_if.m_ready = 1'b1;
        pops_seen    = 0;
        cycle();
        check_val("lat_pop", 32'(pops_seen), 32'd1);
        check_val("lat_valid_early", 32'(mv_sample), 32'd0);
        check_val("lat_valid", 32'(s_if.m_valid), 32'd1);
        check_val("lat_data", 32'(s_if.m_data), 32'h11);
        run_to_idle(50, used);

        // Streaming: 8 bytes back to back, two frames.
        do_reset();
        load_fifo(8'hA0, 8);
        cycle();
        run_to_idle(50, used);
        check_val("stream_cycles", 32'(used + 1), 32'd9);
        check_val("stream_fc", 32'(frame_count), 32'd2);
        check_val("stream_last", 32'(last_frame_byte), 32'hA7);
        check_val("stream_busy", 32'(busy), 32'd0);

        // Backpressure: exactly two pops while the consumer stalls.
        load_fifo(8'hB0, 8);
        s_if.m_ready = 1'b0;
        pops_seen    = 0;
        repeat (5) cycle();
        check_val("bp_pops", 32'(pops_seen), 32'd2);
        check_val("bp_rd_low", 32'(fifo_read_en), 32'd0);
        s_if.m_ready = 1'b1;
        run_to_idle(50, used);
        check_val("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        check_val("bp_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // Enable drop: two buffered bytes drain, frame resumes later.
        load_fifo(8'hC0, 6);
        s_if.m_ready = 1'b0;
        repeat (3) cycle();
        enable       = 1'b0;
        s_if.m_ready = 1'b1;
        cycle();
        check_val("drain_busy", 32'(busy), 32'd1);
        cycle();
        check_val("drain_idle", 32'(busy), 32'd0);
        check_val("drain_valid", 32'(s_if.m_valid), 32'd0);
        pops_seen = 0;
        repeat (3) cycle();
        check_val("disabled_pops", 32'(pops_seen), 32'd0);
        enable = 1'b1;
        cycle();
        run_to_idle(50, used);
        check_val("resume_last", 32'(last_frame_byte), 32'hC3);

        // FIFO empty flag toggling every cycle.
        load_fifo(8'hD0, 6);
        for (int i = 0; i < 60; i++) begin
            force_empty = ~force_empty;
            drive_fifo();
            cycle();
            if (fifo_q.size() == 0 && !busy && !s_if.m_valid) break;
        end
        force_empty = 1'b0;
        drive_fifo();
        run_to_idle(20, used);
        check_val("toggle_done", 32'(fifo_q.size()), 32'd0);
        check_val("toggle_sb", 32'(exp_q.size()), 32'd0);

        // Counter wrap: five frames on a 2-bit counter.
        do_reset();
        load_fifo(8'hE0, 20);
        cycle();
        run_to_idle(100, used);
        check_val("wrap_fc", 32'(frame_count), 32'd1);

        // Async reset with two bytes buffered mid-frame.
        load_fifo(8'hF0, 8);
        repeat (3) cycle();
        s_if.m_ready = 1'b0;
        repeat (2) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(s_if.m_valid), 32'd0);
        check_val("arst_last", 32'(s_if.m_last), 32'd0);
        check_val("arst_fc", 32'(frame_count), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        beat_m     = 0;
        fc_m       = '0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        s_if.m_ready = 1'b1;
        cycle();
        run_to_idle(50, used);
        check_val("post_rst_last", 32'(last_frame_byte), 32'hF7);
        check_val("post_rst_fc", 32'(frame_count), 32'd1);
        check_val("final_sb", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
